// File: rtl/gpio_irq.sv
// gpio_irq: input conditioning and interrupt stage for an 8-pin GPIO port.
//
// Each pin goes through a synchroniser, a debounce filter, and an edge
// detector. Selected edges set pending flags, and the masked flags drive irq.
// Registers sit on the 8-bit peripheral bus, and reads are registered.
//
// Parameters:
//   PRESCALE    debounce tick period in clk cycles (1..65535)
//   SYNC_STAGES synchroniser depth per pin (>= 2)
//
// Optional feature macro: GPIO_IRQ_LEVEL_EN
//   When defined, address 6 becomes the LEVEL register (RW). Any pin with its
//   LEVEL bit set re-asserts PEND every cycle while the enabled level
//   persists. When undefined, address 6 reads the synchronised RAW pins.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   AD    register address
//   DI    write data
//   DO    registered read data
//   rw    1 = read, 0 = write
//   cs    chip select, one access per asserted cycle
//   irq   interrupt request, active-high
//   pins  asynchronous pin inputs
//
// Register map:
//   0 PIN  (R)    1 PEND (R/W1C)  2 MASK (RW)   3 RISE (RW)
//   4 FALL (RW)   5 DBCFG (RW)    6 RAW (R) / LEVEL (RW)
//   7 CTRL (RW): bit0 GIE, bit7 reads irq
module gpio_irq #(
    parameter int PRESCALE    = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic [7:0] pins
);

    localparam logic [15:0] PRESC_RELOAD = 16'(PRESCALE - 1);

    logic       wr_en;
    logic       rd_en;
    logic [7:0] mask;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] dbcfg;
    logic       gie;
    logic [7:0] pend;
    logic [7:0] pend_set;
    logic [7:0] pend_clr;
    logic [7:0] rd_data;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] raw;
    logic [7:0] stable;
    logic [7:0] stable_prev;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] db_cnt [8];
    logic [8:0] cnt_inc [8];

    logic [15:0] presc_cnt;
    logic        tick;

`ifdef GPIO_IRQ_LEVEL_EN
    logic [7:0] level;
`endif

    assign wr_en = cs & ~rw;
    assign rd_en = cs & rw;

    // Tick prescaler: a down-counter that pulses tick at terminal count zero.
    assign tick = (presc_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= 16'd0;
        end else if (tick) begin
            presc_cnt <= PRESC_RELOAD;
        end else begin
            presc_cnt <= presc_cnt - 16'd1;
        end
    end

    // Synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 8'h00;
            end
        end else begin
            sync_q[0] <= pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

    // The commit test is made against the incremented count using >=. A
    // counter that is already past a newly lowered DBCFG therefore commits
    // on its next tick, and it cannot wrap.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_inc[i] = {1'b0, db_cnt[i]} + 9'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (dbcfg == 8'h00) begin
                    stable[i] <= raw[i];
                    db_cnt[i] <= 8'h00;
                end else if (raw[i] == stable[i]) begin
                    db_cnt[i] <= 8'h00;
                end else if (tick) begin
                    if (cnt_inc[i] >= {1'b0, dbcfg}) begin
                        stable[i] <= raw[i];
                        db_cnt[i] <= 8'h00;
                    end else begin
                        db_cnt[i] <= cnt_inc[i][7:0];
                    end
                end
            end
        end
    end

    // stable_prev resets together with stable, so reset cannot create an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev <= 8'h00;
        end else begin
            stable_prev <= stable;
        end
    end

    assign rise = stable & ~stable_prev;
    assign fall = ~stable & stable_prev;

`ifdef GPIO_IRQ_LEVEL_EN
    assign pend_set = (~level & ((rise & rise_en) | (fall & fall_en)))
                    | (level & ((stable & rise_en) | (~stable & fall_en)));
`else
    assign pend_set = (rise & rise_en) | (fall & fall_en);
`endif

    assign pend_clr = (wr_en && AD == 3'd1) ? DI : 8'h00;

    // Within one cycle, a set event takes priority over a W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 8'h00;
        end else begin
            pend <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask    <= 8'h00;
            rise_en <= 8'h00;
            fall_en <= 8'h00;
            dbcfg   <= 8'h00;
            gie     <= 1'b0;
`ifdef GPIO_IRQ_LEVEL_EN
            level   <= 8'h00;
`endif
        end else if (wr_en) begin
            case (AD)
                3'd2: mask    <= DI;
                3'd3: rise_en <= DI;
                3'd4: fall_en <= DI;
                3'd5: dbcfg   <= DI;
`ifdef GPIO_IRQ_LEVEL_EN
                3'd6: level   <= DI;
`endif
                3'd7: gie     <= DI[0];
                default: ;
            endcase
        end
    end

    assign irq = gie & (|(pend & mask));

    always_comb begin
        rd_data = 8'h00;
        case (AD)
            3'd0: rd_data = stable;
            3'd1: rd_data = pend;
            3'd2: rd_data = mask;
            3'd3: rd_data = rise_en;
            3'd4: rd_data = fall_en;
            3'd5: rd_data = dbcfg;
`ifdef GPIO_IRQ_LEVEL_EN
            3'd6: rd_data = level;
`else
            3'd6: rd_data = raw;
`endif
            3'd7: rd_data = {irq, 6'b000000, gie};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DO <= 8'h00;
        end else if (rd_en) begin
            DO <= rd_data;
        end
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq. It is built with PRESCALE=4 so that
// debounce sequences stay short. Each expected read value is queued when the
// read is issued and is compared when DO updates.
module tb_gpio_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic [7:0] pins;

    always #5 clk = ~clk;

    gpio_irq #(.PRESCALE(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .AD  (AD),
        .DI  (DI),
        .DO  (DO),
        .rw  (rw),
        .cs  (cs),
        .irq (irq),
        .pins(pins)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [2:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[16];

    function automatic vec_t mk(input logic [2:0] a, input logic w,
                                input logic [7:0] d, input logic [7:0] e,
                                input string n);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h want 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic e);
        check(name, {7'd0, irq}, {7'd0, e});
    endtask

    // Read monitor: it pops the queued expectation after each captured read.
    initial forever begin
        @(posedge clk);
        if (cs === 1'b1 && rw === 1'b1 && rst === 1'b0) begin
            #1;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got 0x%02h want no read", DO);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check(e.name, DO, e.exp);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
        sb_t s;
        s.exp = e; s.name = n;
        sb_q.push_back(s);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0; rw = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        cs = 1'b0; rw = 1'b1; AD = 3'd0; DI = 8'h00; pins = 8'h00; rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(3'(i), 1'b0, 8'h00, 8'h00, $sformatf("reset_rd%0d", i));
        end
        vecs[8]  = mk(3'd2, 1'b1, 8'hA5, 8'hA5, "mask_rw");
        vecs[9]  = mk(3'd3, 1'b1, 8'h3C, 8'h3C, "rise_rw");
        vecs[10] = mk(3'd4, 1'b1, 8'hC3, 8'hC3, "fall_rw");
        vecs[11] = mk(3'd5, 1'b1, 8'h7E, 8'h7E, "dbcfg_rw");
        vecs[12] = mk(3'd7, 1'b1, 8'hFF, 8'h01, "ctrl_rw");
        vecs[13] = mk(3'd0, 1'b1, 8'hFF, 8'h00, "pin_ro");
        vecs[14] = mk(3'd1, 1'b1, 8'hFF, 8'h00, "pend_w1c_empty");
`ifdef GPIO_IRQ_LEVEL_EN
        vecs[15] = mk(3'd6, 1'b1, 8'hFF, 8'hFF, "level_rw");
`else
        vecs[15] = mk(3'd6, 1'b1, 8'hFF, 8'h00, "raw_ro");
`endif

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_irq("irq_reset", 1'b0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        idle(1);

        // A reset in the middle of the test returns every register to zero.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(3'd2, 8'h00, "mask_rst2");
        rd(3'd5, 8'h00, "dbcfg_rst2");
        rd(3'd7, 8'h00, "ctrl_rst2");

        // Bypass mode: pin change to irq takes exactly four cycles.
        wr(3'd3, 8'h01);
        wr(3'd2, 8'h01);
        wr(3'd7, 8'h01);
        idle(1);
        pins[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_irq("irq_before_c4", 1'b0);
        @(posedge clk);
        #1 chk_irq("irq_at_c4", 1'b1);
        rd(3'd1, 8'h01, "pend_pin0");
        wr(3'd1, 8'h01);
        idle(1);
        chk_irq("irq_after_w1c", 1'b0);
        rd(3'd1, 8'h00, "pend_w1c0");

        // Debounce: DBCFG=3 with a tick every 4 clocks.
        wr(3'd5, 8'h03);
        wr(3'd4, 8'h80);
        idle(1);
        pins[7] = 1'b1;
        idle(30);
        rd(3'd0, 8'h81, "pin7_settled");
        rd(3'd1, 8'h00, "pend_rise7_off");
        idle(1);
        pins[7] = 1'b0;
        idle(8);
        pins[7] = 1'b1;
        idle(12);
        rd(3'd0, 8'h81, "pin7_glitch");
        rd(3'd1, 8'h00, "pend_glitch");
        idle(1);
        pins[7] = 1'b0;
        idle(6);
        rd(3'd0, 8'h81, "pin7_counting");
        idle(14);
        rd(3'd0, 8'h01, "pin7_fell");
        rd(3'd1, 8'h80, "pend_fall7");
        idle(1);
        chk_irq("irq_masked7", 1'b0);
        wr(3'd1, 8'h80);
        wr(3'd5, 8'h00);
        wr(3'd4, 8'h00);

        // MASK and GIE gate only irq. PEND is unaffected by them.
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h04);
        idle(1);
        pins[2] = 1'b1;
        idle(6);
        chk_irq("irq_mask0", 1'b0);
        rd(3'd1, 8'h04, "pend_pin2");
        wr(3'd2, 8'h04);
        idle(1);
        chk_irq("irq_mask4", 1'b1);
        rd(3'd7, 8'h81, "ctrl_irq_bit");
        wr(3'd7, 8'h00);
        idle(1);
        chk_irq("irq_gie0", 1'b0);
        rd(3'd1, 8'h04, "pend_after_gie0");
        rd(3'd7, 8'h00, "ctrl_off");
        wr(3'd1, 8'h04);

        // The set event on pin 3 lands on the same edge as a W1C of bit 3.
        wr(3'd3, 8'h08);
        wr(3'd2, 8'h08);
        wr(3'd7, 8'h01);
        idle(1);
        pins[3] = 1'b1;
        idle(2);
        wr(3'd1, 8'h08);
        idle(1);
        chk_irq("irq_set_wins", 1'b1);
        rd(3'd1, 8'h08, "pend_set_wins");
        wr(3'd1, 8'h00);
        rd(3'd1, 8'h08, "pend_w0_keep");
        wr(3'd1, 8'h08);
        rd(3'd1, 8'h00, "pend_w1c3");
        idle(1);
        chk_irq("irq_clear3", 1'b0);

`ifdef GPIO_IRQ_LEVEL_EN
        wr(3'd6, 8'h02);
        wr(3'd3, 8'h02);
        idle(1);
        pins[1] = 1'b1;
        idle(6);
        wr(3'd1, 8'h02);
        rd(3'd1, 8'h02, "lvl_hold");
        idle(1);
        pins[1] = 1'b0;
        idle(6);
        wr(3'd1, 8'h02);
        rd(3'd1, 8'h00, "lvl_clear");
`else
        rd(3'd6, 8'h0D, "raw_pins");
        wr(3'd6, 8'hFF);
        rd(3'd6, 8'h0D, "raw_wr_ignored");
`endif

        idle(3);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d pending reads want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Input-conditioning and interrupt stage for an 8-pin GPIO port.
- Sits directly downstream of the GPIO pins and drives the CPU irq line.
- Per pin: synchronise, debounce, detect edges, latch pending flags, mask into irq.
- Register-mapped on the same 8-bit peripheral bus as the GPIO block: cs/rw/AD/DI/DO, registered reads.

Parameters:
- PRESCALE, 1000: debounce tick period in clk cycles (tick = one-cycle pulse every PRESCALE clocks); legal range 1..65535.
- SYNC_STAGES, 2: synchroniser flop depth per pin; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: synchronous, active-high
- AD  input  3  register address
- DI  input  8  write data
- DO  output  8  read data, registered
- rw  input  1  1 = read, 0 = write
- cs  input  1  chip select, one access per asserted cycle
- irq  output  1  interrupt request, active-high
- pins  input  8  asynchronous pin inputs, typically the shared GPIO pads

Behaviour:
- Register map, AD[2:0]:
  - 0 PIN (R): debounced stable state.
  - 1 PEND (R, write-1-to-clear).
  - 2 MASK (RW).
  - 3 RISE (RW): rising-edge enables.
  - 4 FALL (RW): falling-edge enables.
  - 5 DBCFG (RW): debounce threshold in ticks.
  - 6 RAW (R): synchronised, undebounced pins.
  - 7 CTRL (RW): bit0 = global enable GIE; bit7 reads irq; bits 6..1 read 0.
- Writes to read-only registers are ignored.
- Reset: DO, PEND, MASK, RISE, FALL, DBCFG, CTRL, stable state, sync flops, debounce counters and prescaler all go to 0.
- Read: on a clk edge with cs=1 and rw=1, DO takes the addressed value; the value is visible the following cycle. DO holds its value when cs=0 or on a write.
- Write: on a clk edge with cs=1 and rw=0, the addressed register updates. The new value takes effect from the next cycle.
- Synchroniser: SYNC_STAGES flops per pin; RAW is the last stage.
- Debounce, per pin, one counter of 8 bits:
  - DBCFG=0: stable follows RAW every clock (bypass). Counter is held at 0.
  - DBCFG>0:
    - RAW == stable: counter is cleared.
    - RAW != stable, on a tick: counter increments.
    - When the counter reaches DBCFG with RAW still != stable: stable <= RAW and the counter clears.
    - Any return of RAW to stable before that point clears the counter.
  - Changing DBCFG mid-count takes effect immediately. A counter already at or above the new value commits on the next tick.
- Edge detect: rise = stable & ~stable_prev; fall = ~stable & stable_prev. stable_prev is stable delayed one clk.
- Pending set: PEND[i] is set on (rise[i] & RISE[i]) | (fall[i] & FALL[i]).
  - PEND is set regardless of MASK and GIE; MASK and GIE gate only irq.
- PEND clear: a write of 1 clears that bit; a write of 0 leaves it.
  - If a set event and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irq = GIE & |(PEND & MASK). Combinational from registers: asserts the cycle after PEND/MASK/GIE update.
- Latency, pin change to PEND (bypass mode): SYNC_STAGES + 1 cycles to stable, +1 to PEND.
- Reset mid-debounce discards the count. No PEND is generated by the reset itself.

Optional Feature:
- Macro GPIO_IRQ_LEVEL_EN.
- Defined:
  - Address 6 becomes LEVEL (RW, reset 0). RAW is no longer readable.
  - For LEVEL[i]=1, PEND[i] is re-set every cycle while (stable & RISE) or (~stable & FALL) holds. A clear is therefore ineffective while the level persists.
  - For LEVEL[i]=0, behaviour is edge mode as above.
- Undefined: address 6 is RAW (read-only); no level logic is synthesised.

Test Plan:
- Reset, then read all 8 addresses -> every read returns 0x00; irq=0.
- DBCFG=0, RISE=0x01, MASK=0x01, CTRL=0x01; drive pins[0] 0->1 -> PEND=0x01 at cycle 4 after the change (SYNC_STAGES=2); irq=1 the same cycle. Write PEND=0x01 -> PEND=0x00, irq=0 next cycle.
- DBCFG=3, PRESCALE=4, FALL=0x80:
  - pins[7] high, settled, then low for 8 clk and back high -> no PEND.
  - pins[7] low for 20 clk -> PIN[7]=0 after the 3rd tick; PEND=0x80.
- MASK=0x00, edge on pin 2 -> PEND=0x04, irq=0. Then write MASK=0x04 -> irq=1. Write CTRL=0x00 -> irq=0, PEND unchanged.
- Rising edge on pin 3 lands in the same cycle as a W1C write of 0x08 -> PEND[3] stays 1.
- GPIO_IRQ_LEVEL_EN: LEVEL=0x02, RISE=0x02, pin 1 held high, write PEND=0x02 -> PEND reads 0x02. Release the pin, then write 0x02 -> PEND=0x00.
